// File: rtl/decode_module.sv
// decode_module: MIPS instruction decode stage.
// Accepts instructions over valid/ready, reads operands from a 32x32 register
// file, and presents a registered ID/EX control/operand bundle with
// backpressure and flush. Hosts the writeback port of the register file.
// Optional macro DECODE_BYPASS_EN: a writeback landing in the same cycle as an
// accept is forwarded into the captured operand (write-through).
module decode_module #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_read_data_1,
  output logic [DATA_W-1:0] alu_read_data_2,
  output logic [DATA_W-1:0] immediate,
  output logic [5:0]        funct,
  output logic [2:0]        alu_op,
  output logic              alu_src,
  output logic [4:0]        dest_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              illegal
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

  // Instruction fields
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic [5:0] fn;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign fn     = instr[5:0];

  // Register file and ID/EX state
  logic [DATA_W-1:0] rf_q [REG_N];
  logic              valid_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic [5:0]        funct_q;
  logic [2:0]        alu_op_q;
  logic              alu_src_q, reg_write_q, mem_read_q, mem_write_q, branch_q, illegal_q;
  logic [4:0]        dest_q;

  // Next-entry values
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d;
  alu_op_e           alu_op_d;
  logic              alu_src_d, reg_write_d, mem_read_d, mem_write_d, branch_d, illegal_d;
  logic [4:0]        dest_d;
  logic              zero_ext;
  logic              accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Register file write port; r0 is never written so it always reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Operand read, optionally forwarding a same-cycle writeback
  always_comb begin
    rd1_d = (rs == '0) ? '0 : rf_q[rs];
    rd2_d = (rt == '0) ? '0 : rf_q[rt];
`ifdef DECODE_BYPASS_EN
    if (wb_we && wb_addr != '0) begin
      if (wb_addr == rs) rd1_d = wb_data;
      if (wb_addr == rt) rd2_d = wb_data;
    end
`else
`endif
  end

  // Opcode/funct decode into the control bundle
  always_comb begin
    alu_op_d    = ALU_ADD;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    illegal_d   = 1'b0;
    dest_d      = '0;
    zero_ext    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            alu_op_d    = ALU_RTYPE;
            dest_d      = rd;
            reg_write_d = 1'b1;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      OP_LW: begin
        alu_src_d   = 1'b1;
        dest_d      = rt;
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
      end
      OP_SW: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      OP_BEQ: begin
        alu_op_d = ALU_SUB;
        branch_d = 1'b1;
      end
      OP_ADDI: begin
        alu_src_d   = 1'b1;
        dest_d      = rt;
        reg_write_d = 1'b1;
      end
      OP_SLTI: begin
        alu_op_d    = ALU_SLT;
        alu_src_d   = 1'b1;
        dest_d      = rt;
        reg_write_d = 1'b1;
      end
      OP_ANDI: begin
        alu_op_d    = ALU_AND;
        alu_src_d   = 1'b1;
        dest_d      = rt;
        reg_write_d = 1'b1;
        zero_ext    = 1'b1;
      end
      OP_ORI: begin
        alu_op_d    = ALU_OR;
        alu_src_d   = 1'b1;
        dest_d      = rt;
        reg_write_d = 1'b1;
        zero_ext    = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    imm_d = zero_ext ? {{(DATA_W-16){1'b0}}, instr[15:0]}
                     : {{(DATA_W-16){instr[15]}}, instr[15:0]};
  end

  // ID/EX valid: flush wins, then accept, then drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 valid_q <= 1'b0;
    else if (flush)             valid_q <= 1'b0;
    else if (accept)            valid_q <= 1'b1;
    else if (out_ready)         valid_q <= 1'b0;
  end

  // ID/EX payload loads only on accept so a stalled entry stays bit-stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      funct_q     <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      funct_q     <= fn;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid       = valid_q;
  assign alu_read_data_1 = rd1_q;
  assign alu_read_data_2 = rd2_q;
  assign immediate       = imm_q;
  assign funct           = funct_q;
  assign alu_op          = alu_op_q;
  assign alu_src         = alu_src_q;
  assign dest_reg        = dest_q;
  assign reg_write       = reg_write_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign branch          = branch_q;
  assign illegal         = illegal_q;

endmodule

// File: tb/tb_decode_module.sv
// Testbench for decode_module: table-driven instruction vectors streamed
// through a scoreboard queue, plus hand-written stall, bypass, flush and
// asynchronous-reset sequences.
module tb_decode_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] alu_read_data_1, alu_read_data_2, immediate;
  logic [5:0]  funct;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic [4:0]  dest_reg;
  logic        reg_write, mem_read, mem_write, branch, illegal;

  decode_module #(.DATA_W(32), .REG_N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_read_data_1(alu_read_data_1), .alu_read_data_2(alu_read_data_2),
    .immediate(immediate), .funct(funct), .alu_op(alu_op), .alu_src(alu_src),
    .dest_reg(dest_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d1, d2, imm;
    logic [5:0]  funct;
    logic [2:0]  alu_op;
    logic        src;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic        src;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, ill;
  } vec_t;

  localparam int NV = 16;
  vec_t        tbl [NV];
  vec_t        cur;
  logic [31:0] mregs [32];
  logic        m_valid;
  exp_t        q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t mkv(logic [31:0] i, logic [31:0] imm, logic [2:0] op,
                               logic src, logic [4:0] dest,
                               logic rw, logic mr, logic mw, logic br, logic ill);
    vec_t v;
    v.instr = i; v.imm = imm; v.alu_op = op; v.src = src; v.dest = dest;
    v.rw = rw; v.mr = mr; v.mw = mw; v.br = br; v.ill = ill;
    return v;
  endfunction

  // Expected bundle from a vector and the bench's shadow register file
  function automatic exp_t mk_exp(vec_t v);
    exp_t e;
    logic [31:0] iw;
    logic [4:0] rs, rt;
    iw = v.instr;
    rs = iw[25:21];
    rt = iw[20:16];
    e.d1 = mregs[rs];
    e.d2 = mregs[rt];
`ifdef DECODE_BYPASS_EN
    if (wb_we && wb_addr != 5'd0) begin
      if (wb_addr == rs) e.d1 = wb_data;
      if (wb_addr == rt) e.d2 = wb_data;
    end
`endif
    e.imm = v.imm; e.funct = iw[5:0]; e.alu_op = v.alu_op; e.src = v.src;
    e.dest = v.dest; e.rw = v.rw; e.mr = v.mr; e.mw = v.mw; e.br = v.br; e.ill = v.ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bundle(input exp_t e);
    chk("alu_read_data_1", alu_read_data_1, e.d1);
    chk("alu_read_data_2", alu_read_data_2, e.d2);
    chk("immediate", immediate, e.imm);
    chk("funct", {26'd0, funct}, {26'd0, e.funct});
    chk("alu_op", {29'd0, alu_op}, {29'd0, e.alu_op});
    chk("alu_src", {31'd0, alu_src}, {31'd0, e.src});
    chk("dest_reg", {27'd0, dest_reg}, {27'd0, e.dest});
    chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
    chk("mem_read", {31'd0, mem_read}, {31'd0, e.mr});
    chk("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
    chk("branch", {31'd0, branch}, {31'd0, e.br});
    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
  endtask

  // One clock: predict handshake, update scoreboard, then compare after the edge
  task automatic step();
    logic acc;
    exp_t e;
    instr = cur.instr;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    acc = in_valid && !flush && (!m_valid || out_ready);
    e = '0;
    if (acc) e = mk_exp(cur);
    if (m_valid && (out_ready || flush) && q.size() > 0) q.delete(0);
    if (acc) q.push_back(e);
    if (flush)          m_valid = 1'b0;
    else if (acc)       m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (wb_we && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      if (q.size() > 0) check_bundle(q[0]);
      else begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard: got empty queue expected one entry");
      end
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b0;
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_we = 1'b0;
  endtask

  localparam int V_LW = 0, V_ANDI = 1, V_ADDI = 2, V_ADD5 = 12, V_BEQ = 6;

  initial begin
    exp_t zero;
    zero = '0;
    //                 instr          imm            op     src dest rw mr mw br ill
    tbl[0]  = mkv(32'h8C410004, 32'h00000004, 3'b000, 1, 5'd1, 1, 1, 0, 0, 0); // lw
    tbl[1]  = mkv(32'h3043FFFF, 32'h0000FFFF, 3'b011, 1, 5'd3, 1, 0, 0, 0, 0); // andi
    tbl[2]  = mkv(32'h2043FFFF, 32'hFFFFFFFF, 3'b000, 1, 5'd3, 1, 0, 0, 0, 0); // addi
    tbl[3]  = mkv(32'h34438001, 32'h00008001, 3'b100, 1, 5'd3, 1, 0, 0, 0, 0); // ori
    tbl[4]  = mkv(32'h28438001, 32'hFFFF8001, 3'b101, 1, 5'd3, 1, 0, 0, 0, 0); // slti
    tbl[5]  = mkv(32'hAC430008, 32'h00000008, 3'b000, 1, 5'd0, 0, 0, 1, 0, 0); // sw
    tbl[6]  = mkv(32'h10430003, 32'h00000003, 3'b001, 0, 5'd0, 0, 0, 0, 1, 0); // beq
    tbl[7]  = mkv(32'h00433822, 32'h00003822, 3'b010, 0, 5'd7, 1, 0, 0, 0, 0); // sub
    tbl[8]  = mkv(32'h0043382A, 32'h0000382A, 3'b010, 0, 5'd7, 1, 0, 0, 0, 0); // slt
    tbl[9]  = mkv(32'h00433824, 32'h00003824, 3'b010, 0, 5'd7, 1, 0, 0, 0, 0); // and
    tbl[10] = mkv(32'h00433825, 32'h00003825, 3'b010, 0, 5'd7, 1, 0, 0, 0, 0); // or
    tbl[11] = mkv(32'h00003020, 32'h00003020, 3'b010, 0, 5'd6, 1, 0, 0, 0, 0); // add r0,r0
    tbl[12] = mkv(32'h00A53020, 32'h00003020, 3'b010, 0, 5'd6, 1, 0, 0, 0, 0); // add r5,r5
    tbl[13] = mkv(32'h00433800, 32'h00003800, 3'b000, 0, 5'd0, 0, 0, 0, 0, 1); // bad funct
    tbl[14] = mkv(32'hFC430005, 32'h00000005, 3'b000, 0, 5'd0, 0, 0, 0, 0, 1); // op 111111
    tbl[15] = mkv(32'h0C000000, 32'h00000000, 3'b000, 0, 5'd0, 0, 0, 0, 0, 1); // jal: unsupported

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; wb_we = 1'b0; wb_addr = '0;
    wb_data = '0; flush = 1'b0; out_ready = 1'b1; cur = tbl[V_LW];
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_valid = 1'b0;
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_bundle(zero);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload registers; the r0 write must be ignored
    wb_write(5'd1, 32'h00000011);
    wb_write(5'd2, 32'h00000010);
    wb_write(5'd3, 32'h00000033);
    wb_write(5'd5, 32'h00005555);
    wb_write(5'd0, 32'hDEADBEEF);

    // First lw with explicit operand check
    cur = tbl[V_LW]; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("lw_rs_value", alu_read_data_1, 32'h00000010);

    // Back-to-back stream of every vector
    for (int i = 0; i < NV; i++) begin
      cur = tbl[i];
      step();
    end
    in_valid = 1'b0;
    step();

    // Stall three cycles with the next instruction held, then release
    cur = tbl[V_LW]; in_valid = 1'b1; out_ready = 1'b1;
    step();
    cur = tbl[V_ADDI]; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();

    // Same-cycle writeback of r5 and accept of add r6,r5,r5
    cur = tbl[V_ADD5]; in_valid = 1'b1; out_ready = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000ABCD;
    step();
    wb_we = 1'b0;
`ifdef DECODE_BYPASS_EN
    chk("same_cycle_rs", alu_read_data_1, 32'h0000ABCD);
    chk("same_cycle_rt", alu_read_data_2, 32'h0000ABCD);
`else
    chk("same_cycle_rs", alu_read_data_1, 32'h00005555);
    chk("same_cycle_rt", alu_read_data_2, 32'h00005555);
`endif
    in_valid = 1'b0;
    step();

    // Flush a held beq while a new instruction is offered
    cur = tbl[V_BEQ]; in_valid = 1'b1; out_ready = 1'b1;
    step();
    cur = tbl[V_ADDI]; out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    // Flush with downstream ready still blocks the accept
    cur = tbl[V_BEQ]; in_valid = 1'b1;
    step();
    cur = tbl[V_ANDI]; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of a stall
    cur = tbl[V_LW]; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_bundle(zero);
    q.delete();
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    // Register file was cleared by reset
    cur = tbl[V_LW]; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("post_reset_rs", alu_read_data_1, 32'h00000000);
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
